// File: rtl/truth_table_scanner.sv
// truth_table_scanner
//   Drives a 4-input function block through all 16 input codes in ascending
//   order and holds each code for DWELL clock cycles. On the last cycle of
//   each dwell it samples the block's output and stores it in a 16-entry
//   truth table. It also keeps a running count of the set entries. One
//   start pulse produces one full exhaustive sweep.
//
// Parameters
//   DWELL        clock cycles each code is held (1..16)
//
// Ports
//   clk          clock, rising edge
//   rst          asynchronous reset, active high
//   start        begin a sweep (sampled only while idle)
//   f            output of the function block under scan
//   W[3:0]       code driven to the function block
//   En           function block enable, high only while sweeping
//   truth_table  captured table, bit i = f observed for W = i
//   ones[4:0]    number of set bits in truth_table (0..16)
//   busy         high while the sweep is in progress
//   done         one-cycle pulse when a sweep completes
//
// States
//   IDLE  | waiting for start; W=0, En=0; table/ones hold last result
//   DRIVE | sweep in progress; code W held for DWELL cycles
//   DONE  | single cycle with done=1, then back to IDLE

module truth_table_scanner #(
  parameter int DWELL = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        f,
  output logic [3:0]  W,
  output logic        En,
  output logic [15:0] truth_table,
  output logic [4:0]  ones,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Terminal count of the dwell counter; f is sampled when cnt reaches it.
  localparam logic [3:0] CNT_LAST = 4'(DWELL - 1);

  state_t     state;
  logic [3:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      W           <= '0;
      En          <= 1'b0;
      truth_table <= '0;
      ones        <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            state       <= DRIVE;
            W           <= '0;
            En          <= 1'b1;
            busy        <= 1'b1;
            cnt         <= '0;
            truth_table <= '0;
            ones        <= '0;
          end
        end

        DRIVE: begin
          if (cnt != CNT_LAST) begin
            cnt <= cnt + 4'd1;
          end else begin
            // Last cycle of the dwell: capture f for the code being driven.
            truth_table[W] <= f;
            ones           <= ones + {4'b0000, f};
            cnt            <= '0;
            if (W != 4'd15) begin
              W <= W + 4'd1;
            end else begin
              // Final code captured; release the block and report.
              W     <= '0;
              En    <= 1'b0;
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= DONE;
            end
          end
        end

        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
          En    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_truth_table_scanner.sv
// Scoreboard bench for truth_table_scanner. Two instances are used, with
// DWELL=4 and DWELL=1. Each function block is modelled as a lookup table,
// f = lut[W]. The expected result of a sweep is therefore the lut itself,
// and the expected popcount is counted bit by bit. Monitors pop the
// expected result whenever a done pulse appears. They also follow the code
// sequence while busy is high.

module tb_truth_table_scanner;

  typedef struct {
    logic [15:0] tbl;
    logic [4:0]  ones;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        start4, start1;
  logic [15:0] lut4, lut1;

  logic [3:0]  W4, W1;
  logic        En4, En1, f4, f1;
  logic [15:0] tbl4, tbl1;
  logic [4:0]  ones4, ones1;
  logic        busy4, busy1, done4, done1;

  int n_cmp  = 0;
  int n_fail = 0;

  exp_t q4[$];
  exp_t q1[$];
  int   cyc4 = 0, cyc1 = 0;
  logic prev_done4 = 1'b0, prev_done1 = 1'b0;

  assign f4 = lut4[W4];
  assign f1 = lut1[W1];

  truth_table_scanner #(.DWELL(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .f(f4),
    .W(W4), .En(En4), .truth_table(tbl4), .ones(ones4),
    .busy(busy4), .done(done4)
  );

  truth_table_scanner #(.DWELL(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .f(f1),
    .W(W1), .En(En1), .truth_table(tbl1), .ones(ones1),
    .busy(busy1), .done(done1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit is_prime(input int n);
    if (n < 2) return 1'b0;
    for (int d = 2; d < n; d++)
      if (n % d == 0) return 1'b0;
    return 1'b1;
  endfunction

  // 0: W[0]  1: prime(W)  2: const 1  3: const 0  4: W[3]  other: random
  function automatic logic [15:0] gen_lut(input int mode);
    logic [15:0] l;
    l = '0;
    for (int i = 0; i < 16; i++) begin
      case (mode)
        0:       l[i] = (i % 2) == 1;
        1:       l[i] = is_prime(i);
        2:       l[i] = 1'b1;
        3:       l[i] = 1'b0;
        4:       l[i] = i >= 8;
        default: l[i] = $urandom_range(0, 1) == 1;
      endcase
    end
    return l;
  endfunction

  function automatic exp_t model(input logic [15:0] l);
    exp_t e;
    int   c;
    c = 0;
    for (int i = 0; i < 16; i++)
      if (l[i]) c++;
    e.tbl  = l;
    e.ones = 5'(c);
    return e;
  endfunction

  // Monitor for the DWELL=4 instance.
  always @(negedge clk) begin
    exp_t e;
    if (done4) begin
      check("d4_done_single", {31'b0, prev_done4}, 0);
      if (q4.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL d4_unexpected_done: got done with empty queue, expected none at %0t", $time);
      end else begin
        e = q4.pop_front();
        check("d4_table", {16'b0, tbl4}, {16'b0, e.tbl});
        check("d4_ones", {27'b0, ones4}, {27'b0, e.ones});
        check("d4_sweep_len", cyc4, 64);
        check("d4_en_off", {31'b0, En4}, 0);
      end
    end
    if (busy4) begin
      check("d4_code", {28'b0, W4}, cyc4 / 4);
      check("d4_en_on", {31'b0, En4}, 1);
      cyc4++;
    end else begin
      cyc4 = 0;
    end
    prev_done4 = done4;
  end

  // Monitor for the DWELL=1 instance.
  always @(negedge clk) begin
    exp_t e;
    if (done1) begin
      check("d1_done_single", {31'b0, prev_done1}, 0);
      if (q1.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL d1_unexpected_done: got done with empty queue, expected none at %0t", $time);
      end else begin
        e = q1.pop_front();
        check("d1_table", {16'b0, tbl1}, {16'b0, e.tbl});
        check("d1_ones", {27'b0, ones1}, {27'b0, e.ones});
        check("d1_sweep_len", cyc1, 16);
      end
    end
    if (busy1) begin
      check("d1_code", {28'b0, W1}, cyc1);
      cyc1++;
    end else begin
      cyc1 = 0;
    end
    prev_done1 = done1;
  end

  task automatic wait_done4(input int budget);
    int i;
    for (i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done4) break;
    end
    if (i == budget) begin
      n_cmp++;
      n_fail++;
      $display("FAIL d4_timeout: got no done in %0d cycles, expected done", budget);
    end
  endtask

  task automatic wait_done1(input int budget);
    int i;
    for (i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done1) break;
    end
    if (i == budget) begin
      n_cmp++;
      n_fail++;
      $display("FAIL d1_timeout: got no done in %0d cycles, expected done", budget);
    end
  endtask

  task automatic sweep4(input logic [15:0] l);
    exp_t e;
    lut4 = l;
    e    = model(l);
    q4.push_back(e);
    @(posedge clk); #1 start4 = 1'b1;
    @(posedge clk); #1 start4 = 1'b0;
    wait_done4(200);
    repeat (3) @(negedge clk);
    check("d4_hold_table", {16'b0, tbl4}, {16'b0, e.tbl});
    check("d4_hold_ones", {27'b0, ones4}, {27'b0, e.ones});
  endtask

  task automatic sweep1(input logic [15:0] l);
    lut1 = l;
    q1.push_back(model(l));
    @(posedge clk); #1 start1 = 1'b1;
    @(posedge clk); #1 start1 = 1'b0;
    wait_done1(60);
  endtask

  task automatic check_reset4(input string tag);
    check({tag, "_W"}, {28'b0, W4}, 0);
    check({tag, "_En"}, {31'b0, En4}, 0);
    check({tag, "_table"}, {16'b0, tbl4}, 0);
    check({tag, "_ones"}, {27'b0, ones4}, 0);
    check({tag, "_busy"}, {31'b0, busy4}, 0);
    check({tag, "_done"}, {31'b0, done4}, 0);
  endtask

  initial begin
    exp_t e;
    int   i;
    rst    = 1'b1;
    start4 = 1'b0;
    start1 = 1'b0;
    lut4   = '0;
    lut1   = '0;
    #12;
    check_reset4("rst_init");
    check("rst_init_d1_busy", {31'b0, busy1}, 0);
    #11 rst = 1'b0;

    // Fixed functions, DWELL=4.
    sweep4(gen_lut(0));
    sweep4(gen_lut(1));
    sweep4(gen_lut(2));
    sweep4(gen_lut(3));
    // Random functions, DWELL=4.
    for (int k = 0; k < 3; k++) sweep4(gen_lut(5));

    // DWELL=1: W[3], then random.
    sweep1(gen_lut(4));
    for (int k = 0; k < 2; k++) sweep1(gen_lut(5));

    // Extra start pulses at cycles 5 and 30 of a sweep are ignored.
    lut4 = gen_lut(5);
    q4.push_back(model(lut4));
    @(posedge clk); #1 start4 = 1'b1;
    @(posedge clk); #1 start4 = 1'b0;
    repeat (4) @(posedge clk);
    #1 start4 = 1'b1;
    @(posedge clk); #1 start4 = 1'b0;
    repeat (24) @(posedge clk);
    #1 start4 = 1'b1;
    @(posedge clk); #1 start4 = 1'b0;
    wait_done4(200);
    repeat (70) @(negedge clk);
    check("extra_start_no_restart", {31'b0, busy4}, 0);

    // Asynchronous reset during code 7.
    lut4 = gen_lut(5);
    q4.push_back(model(lut4));
    @(posedge clk); #1 start4 = 1'b1;
    @(posedge clk); #1 start4 = 1'b0;
    for (i = 0; i < 200; i++) begin
      @(negedge clk);
      if (W4 == 4'd7 && En4) break;
    end
    check("reach_code7", i < 200, 1);
    @(posedge clk);
    #2 rst = 1'b1;
    #1 check_reset4("rst_mid");
    #1 rst = 1'b0;
    q4.delete();
    repeat (2) @(negedge clk);
    check_reset4("rst_after");

    // Complete sweep after the aborted one.
    sweep4(gen_lut(1));

    // start held high: back-to-back sweeps with one idle cycle between.
    lut4 = gen_lut(5);
    e    = model(lut4);
    q4.push_back(e);
    q4.push_back(e);
    @(posedge clk); #1 start4 = 1'b1;
    wait_done4(200);
    @(negedge clk);
    check("b2b_idle_busy", {31'b0, busy4}, 0);
    check("b2b_idle_done", {31'b0, done4}, 0);
    check("b2b_idle_table", {16'b0, tbl4}, {16'b0, e.tbl});
    @(negedge clk);
    check("b2b_restart_busy", {31'b0, busy4}, 1);
    check("b2b_restart_table", {16'b0, tbl4}, 0);
    check("b2b_restart_ones", {27'b0, ones4}, 0);
    start4 = 1'b0;
    wait_done4(200);

    repeat (5) @(negedge clk);
    check("q4_drained", q4.size(), 0);
    check("q1_drained", q1.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/truth_table_scanner.md
# truth_table_scanner

Sequential sweep-and-capture stage wrapped around a 4-input combinational function block with enable.
- Upstream, it drives the function's `W`/`En` inputs through all 16 codes in ascending order, holding each code for a programmable dwell.
- Downstream, it samples the function's output `f` at the end of each dwell, builds the 16-entry truth table and counts its minterms.
- It replaces hand-written per-code stimulus with one `start` pulse, giving automated exhaustive checking of function blocks.

## Interface
Parameters:
- `DWELL`, default 4, clock cycles each code is held (legal range 1..16); `f` is sampled on the last cycle of the dwell.

Ports:
- `clk` in 1: single clock; all state changes on the rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `start` in 1: begin a sweep; sampled only in IDLE.
- `f` in 1: output of the function block under scan.
- `W` out 4: code driven to the function block.
- `En` out 1: enable to the function block; high only while sweeping.
- `table` out 16: captured truth table; bit i = `f` observed for `W` = i.
- `ones` out 5: number of set bits in `table` (0..16).
- `busy` out 1: high while in DRIVE.
- `done` out 1: one-cycle pulse when a sweep completes.

## Operation
- States:
  - IDLE: `W`=0, `En`=0, `busy`=0.
  - DRIVE: sweep in progress.
  - DONE: one cycle, `done`=1.
- IDLE → DRIVE on an edge with `start`=1. On that edge:
  - `W`<=0, `En`<=1.
  - Dwell counter `cnt`<=0.
  - `table`<=0, `ones`<=0.
- DRIVE, each edge:
  - If `cnt` < `DWELL`-1: `cnt`++.
  - Else (sample edge): `table[W]`<=`f`; `ones`<=`ones`+`f`; `cnt`<=0.
    - If `W` < 15: `W`<=`W`+1.
    - If `W` = 15: `W`<=0, `En`<=0, `done`<=1, go to DONE.
- DONE → IDLE on the next edge, with `done`<=0.
- `table` and `ones` hold their final values in IDLE until the next accepted `start`.
- `start` is ignored in DRIVE and DONE; it is not queued.
- `start` held high continuously:
  - A new sweep starts on the first edge in IDLE.
  - This gives back-to-back sweeps with exactly one IDLE cycle between them.
- `ones` is 5 bits wide so the all-ones table (16) does not wrap.
- `W` never exceeds 15 and never wraps while `En`=1.

## Timing
- All outputs are registered; no combinational path from `f` or `start` to any output.
- Reset values:
  - `W`=0, `En`=0, `table`=0, `ones`=0, `busy`=0, `done`=0.
  - State = IDLE, `cnt`=0.
- Asserting `rst` mid-sweep aborts immediately and asynchronously to the reset values; the partial table is discarded.
- Let the start edge be edge 0:
  - `En`=1 and `W`=0 become visible after edge 0.
  - Code i is driven between edges i·`DWELL` and (i+1)·`DWELL`.
  - `f` for code i is sampled at edge (i+1)·`DWELL`.
  - `done`=1 after edge 16·`DWELL` for exactly one cycle.
  - `busy`=0 from that same edge.
- The function block must settle within `DWELL` cycles minus setup; with `DWELL`=1, `f` must be valid within one cycle of `W` changing.

## Test plan
- Bench models `f` = `W`[0], `DWELL`=4, pulse `start` → `W` steps 0..15 every 4 cycles with `En`=1; `done` after 64 edges; `table`=0xAAAA, `ones`=8.
- `f` = prime(`W`) (codes 2,3,5,7,11,13) → `table`=0x28AC, `ones`=6; `f`≡1 → `table`=0xFFFF, `ones`=16; `f`≡0 → 0x0000, `ones`=0.
- `DWELL`=1 build with `f` = `W`[3] → `done` 16 edges after start, `table`=0xFF00, `ones`=8, `busy` high for exactly 16 cycles.
- Extra `start` pulses at cycles 5 and 30 of a sweep → ignored; sweep length and result unchanged; single `done` pulse.
- Assert `rst` asynchronously during code 7 → all outputs return to reset values before the next edge; a later `start` produces a complete, correct table.
- Hold `start`=1 for two sweeps → second sweep begins one cycle after `done`; `table` clears at the second start edge; both results correct.
